grant_mux: RTL
==============

# grant_mux

Downstream consumer of the round-robin arbiter. Takes the arbiter's one-hot `grant` vector, selects the granted client's payload and client index, and registers them into a 2-entry output FIFO with a valid/ready handshake. It drives the arbiter's `stall` input, so the arbiter holds its grant while the output side is backed up.

## Interface
- `CLIENTS`, 32: number of arbiter clients; must be ≥2.
- `DATA_W`, 32: payload width per client.
- `IDX_W`, `$clog2(CLIENTS)`: client index width; derived, not overridden.

Ports:
- `clock`  in  1  sole clock; all state updates on posedge.
- `reset`  in  1  asynchronous, active-low reset.
- `grant`  in  CLIENTS  one-hot-or-zero grant from the arbiter.
- `payload`  in  CLIENTS*DATA_W  flattened client payloads; client i occupies bits [i*DATA_W +: DATA_W].
- `stall`  out  1  back-pressure to the arbiter; high means no grant is accepted this cycle.
- `out_valid`  out  1  head entry is valid.
- `out_ready`  in  1  consumer accepts the head entry.
- `out_data`  out  DATA_W  head entry payload.
- `out_client`  out  IDX_W  head entry client index.

## Operation
- Push: `grant != 0 && !stall` captures `payload[idx]` and `idx` into the tail entry. `idx` is the encoded position of the set grant bit.
- Pop: `out_valid && out_ready` removes the head entry.
- Storage is a 2-entry FIFO with read pointer, write pointer and `count` in {0,1,2}.
  - Pointers are 1 bit and wrap 1→0.
  - `count` next = `count` + push − pop.
- `stall = (count == 2)`. It is a function of registered state only; there is no combinational path from `out_ready` or `grant` to `stall`.
- When full, push is blocked by `stall`. A pop in that same cycle frees a slot, and `stall` drops on the next cycle.
- A push and a pop in the same cycle at `count == 1` leave `count` at 1. The new entry becomes the head on the next cycle.
- `grant == 0`: no push.
- Multi-hot grant is illegal input. With the checks disabled, the lowest set bit wins.
- `out_data` and `out_client` are held stable while `out_valid && !out_ready`.
- Reset (asynchronous, any time):
  - `count`, pointers and `out_valid` go to 0.
  - `stall` goes to 0.
  - Stored entries are discarded; `out_data` and `out_client` read 0.
  - A push in flight when reset asserts is lost.

## Timing
- Latency from grant accepted on cycle N to `out_valid` on cycle N+1 is 1 cycle.
- Sustained throughput is 1 entry/cycle when `out_ready` is held high.
- `stall` rises the cycle after the second un-popped push. It falls the cycle after a pop from full.
- Outputs are registered; there are no combinational input-to-output paths.

## Configuration
- `GRANT_MUX_CHECKS_EN` defined: concurrent SVA compiled in, each with `@(posedge clock) disable iff (!reset)`:
  - Assert `$onehot0(grant)`.
  - Assert that `out_valid && !out_ready` implies `out_valid`, `out_data` and `out_client` are `$stable` at the next edge.
  - Assert that `stall` implies `count == 2`.
  - Cover a full→pop→push sequence.
- `GRANT_MUX_CHECKS_EN` undefined: no assertions; RTL behaviour is identical.

## Structure
- `grant_mux_pkg` holds:
  - the `fifo_cnt_t` typedef (2 bits);
  - an entry struct parameterised through localparams at the use site;
  - the function `onehot_idx` (lowest set bit → index).
- Sub-module `onehot_enc`: parameterised one-hot-to-index encoder with a `found` output. `grant_mux` instantiates it once on `grant`.

## Test plan
- Reset, then `grant=32'h0000_0010`, `payload[4]=32'hCAFE_0004`, `out_ready=1`. Next cycle: `out_valid=1`, `out_data=32'hCAFE_0004`, `out_client=4`. `stall` stays 0.
- `out_ready=0` with grants to clients 1 then 2 on consecutive cycles. `stall=1` on the third cycle. A grant to client 3 on that cycle is not captured. Head stays client 1 and its data is stable.
- From full, raise `out_ready` for one cycle. Client 1 pops. `stall=0` the next cycle. A grant to client 3 is then captured behind client 2, in order 2, 3.
- Continuous grants to clients 0..31 round robin with `out_ready=1`. Output produces 32 consecutive entries with indices 0..31 and `stall` never asserts.
- Assert reset mid-operation with `count=2`. `out_valid=0`, `stall=0` and `out_data=0` immediately (asynchronous). After release, the first grant appears 1 cycle later.
- With `GRANT_MUX_CHECKS_EN`, drive `grant=32'h0000_0003`: the onehot assertion fires. Without the macro, `out_client=0` is captured.

Source files
------------

// File: rtl/grant_mux_pkg.sv
// Shared types and helpers for grant_mux: FIFO count type, default entry
// layout and a lowest-set-bit encoder function.
package grant_mux_pkg;

  localparam int unsigned ONEHOT_MAX_W = 256;
  localparam int unsigned ENTRY_DATA_W = 32;
  localparam int unsigned ENTRY_IDX_W  = 5;

  typedef logic [1:0] fifo_cnt_t;

  localparam fifo_cnt_t CNT_EMPTY = 2'd0;
  localparam fifo_cnt_t CNT_FULL  = 2'd2;

  // Default-sized entry; users with other widths declare the same layout locally.
  typedef struct packed {
    logic [ENTRY_IDX_W-1:0]  client;
    logic [ENTRY_DATA_W-1:0] data;
  } entry_t;

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic int unsigned onehot_idx(input logic [ONEHOT_MAX_W-1:0] vec);
    int unsigned idx;
    idx = 0;
    for (int i = ONEHOT_MAX_W - 1; i >= 0; i--) begin
      if (vec[i]) idx = $unsigned(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/grant_mux_onehot_enc.sv
// One-hot (or zero) to binary index encoder; the lowest set bit wins on
// multi-hot input.
module onehot_enc
  import grant_mux_pkg::*;
#(
  parameter  int unsigned N  = 32,
  localparam int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  i_onehot,
  output logic [IW-1:0] o_idx,
  output logic          o_found
);

  if (N > ONEHOT_MAX_W) begin : g_width_check
    $error("onehot_enc: N exceeds ONEHOT_MAX_W");
  end

  always_comb begin
    o_idx   = IW'(onehot_idx(ONEHOT_MAX_W'(i_onehot)));
    o_found = |i_onehot;
  end

endmodule

// File: rtl/grant_mux.sv
// Selects the granted client's payload and index into a 2-entry output FIFO
// and back-pressures the arbiter via stall. Define GRANT_MUX_CHECKS_EN for SVA.
module grant_mux
  import grant_mux_pkg::*;
#(
  parameter  int unsigned CLIENTS = 32,
  parameter  int unsigned DATA_W  = 32,
  localparam int unsigned IDX_W   = $clog2(CLIENTS)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [CLIENTS-1:0]        grant,
  input  logic [CLIENTS*DATA_W-1:0] payload,
  output logic                      stall,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic [IDX_W-1:0]          out_client
);

  if (CLIENTS < 2) begin : g_clients_check
    $error("grant_mux: CLIENTS must be at least 2");
  end

  typedef struct packed {
    logic [IDX_W-1:0]  client;
    logic [DATA_W-1:0] data;
  } mux_entry_t;

  logic [IDX_W-1:0] w_idx;
  logic             w_found;
  logic             w_push;
  logic             w_pop;
  fifo_cnt_t        w_cnt_nxt;
  mux_entry_t       w_wr_entry;

  mux_entry_t r_mem [2];
  fifo_cnt_t  r_count;
  logic       r_wr_ptr;
  logic       r_rd_ptr;
  logic       r_stall;
  logic       r_valid;

  onehot_enc #(
    .N (CLIENTS)
  ) u_enc (
    .i_onehot (grant),
    .o_idx    (w_idx),
    .o_found  (w_found)
  );

  // Handshake decode and next occupancy; stall/valid only look at registers.
  always_comb begin
    w_push            = 1'b0;
    w_pop             = 1'b0;
    w_wr_entry        = '0;
    w_cnt_nxt         = r_count;
    w_push            = w_found && !r_stall;
    w_pop             = r_valid && out_ready;
    w_wr_entry.client = w_idx;
    w_wr_entry.data   = payload[32'(w_idx) * DATA_W +: DATA_W];
    w_cnt_nxt         = r_count + fifo_cnt_t'(w_push) - fifo_cnt_t'(w_pop);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) r_mem[i] <= '0;
      r_count  <= CNT_EMPTY;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_stall  <= 1'b0;
      r_valid  <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_wr_entry;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      r_count <= w_cnt_nxt;
      r_stall <= (w_cnt_nxt == CNT_FULL);
      r_valid <= (w_cnt_nxt != CNT_EMPTY);
    end
  end

  assign stall      = r_stall;
  assign out_valid  = r_valid;
  assign out_data   = r_mem[r_rd_ptr].data;
  assign out_client = r_mem[r_rd_ptr].client;

`ifdef GRANT_MUX_CHECKS_EN
  a_grant_onehot0: assert property (@(posedge clock) disable iff (!reset)
    $onehot0(grant));

  a_head_hold: assert property (@(posedge clock) disable iff (!reset)
    out_valid && !out_ready |=>
      $stable(out_valid) && $stable(out_data) && $stable(out_client));

  a_stall_full: assert property (@(posedge clock) disable iff (!reset)
    stall |-> r_count == CNT_FULL);

  c_full_pop_push: cover property (@(posedge clock) disable iff (!reset)
    (r_count == CNT_FULL && w_pop) ##1 w_push);
`endif

endmodule
